// File: rtl/cli_pkg.sv
// Shared constants for the command-line-interface steering blocks.
package cli_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned NUM_CH = 3;

    // Select encoding shared with the MUX_3 selector.
    localparam logic [1:0] SEL_CH1  = 2'd0;
    localparam logic [1:0] SEL_CH2  = 2'd1;
    localparam logic [1:0] SEL_CH3  = 2'd2;
    localparam logic [1:0] SEL_DROP = 2'd3;

endpackage

// File: rtl/demux_slot.sv
// One-entry register slice: holds a word until the consumer takes it,
// and accepts a new word in the same cycle the old one drains.
module demux_slot #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              out_ready,
    output logic              ready_c,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q,  data_d;

    assign ready_c   = ~valid_q | out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    // EMPTY/FULL flag: load wins over drain so back-to-back words never bubble.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/demux_3_stream.sv
// 1-to-3 valid/ready steering stage; select 3 consumes and counts the word.
module demux_3_stream #(
    parameter int unsigned DATA_W = cli_pkg::DATA_W,
    parameter int unsigned CNT_W  = cli_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_sel,
    output logic [2:0]        out_valid,
    input  logic [2:0]        out_ready,
    output logic [DATA_W-1:0] out_data_1,
    output logic [DATA_W-1:0] out_data_2,
    output logic [DATA_W-1:0] out_data_3,
    output logic              drop_pulse,
    output logic [CNT_W-1:0]  drop_count
);

    import cli_pkg::*;

    logic [NUM_CH-1:0] slot_ready_c;
    logic [NUM_CH-1:0] slot_load;
    logic [DATA_W-1:0] slot_data [NUM_CH];
    logic              acc;
    logic              drop_acc;

    logic              drop_pulse_q, drop_pulse_d;
    logic [CNT_W-1:0]  drop_count_q, drop_count_d;

    // in_ready follows the selected slot only; in_valid is deliberately not involved.
    always_comb begin
        in_ready = 1'b1;
        unique case (in_sel)
            SEL_CH1:  in_ready = slot_ready_c[0];
            SEL_CH2:  in_ready = slot_ready_c[1];
            SEL_CH3:  in_ready = slot_ready_c[2];
            default:  in_ready = 1'b1;
        endcase
    end

    assign acc      = in_valid & in_ready;
    assign drop_acc = acc & (in_sel == SEL_DROP);

    always_comb begin
        slot_load = '0;
        if (acc && in_sel != SEL_DROP) begin
            slot_load[in_sel] = 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        demux_slot #(.DATA_W(DATA_W)) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (slot_load[k]),
            .load_data (in_data),
            .out_ready (out_ready[k]),
            .ready_c   (slot_ready_c[k]),
            .out_valid (out_valid[k]),
            .out_data  (slot_data[k])
        );
    end

    assign out_data_1 = slot_data[0];
    assign out_data_2 = slot_data[1];
    assign out_data_3 = slot_data[2];

    // Drop pulse and saturating counter.
    always_comb begin
        drop_pulse_d = drop_acc;
        drop_count_d = drop_count_q;
        if (drop_acc && drop_count_q != '1) begin
            drop_count_d = drop_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_pulse_q <= 1'b0;
            drop_count_q <= '0;
        end else begin
            drop_pulse_q <= drop_pulse_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_pulse = drop_pulse_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_demux_3_stream.sv
// Directed bench for demux_3_stream: routing, backpressure, throughput,
// channel independence, reset and saturating drop counting.
module tb_demux_3_stream;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [1:0]        in_sel;
    logic [2:0]        out_valid;
    logic [2:0]        out_ready;
    logic [DATA_W-1:0] out_data_1;
    logic [DATA_W-1:0] out_data_2;
    logic [DATA_W-1:0] out_data_3;
    logic              drop_pulse;
    logic [CNT_W-1:0]  drop_count;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    demux_3_stream #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data_1 (out_data_1),
        .out_data_2 (out_data_2),
        .out_data_3 (out_data_3),
        .drop_pulse (drop_pulse),
        .drop_count (drop_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Step past the next rising edge; outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [31:0] d);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        #1;
    endtask

    initial begin
        int pulses;
        int lows;

        rst_n     = 1'b0;
        out_ready = 3'b111;
        drive(1'b0, 2'd0, 32'h0);
        tick();
        check("rst_valid", 64'(out_valid), 64'h0);
        check("rst_cnt",   64'(drop_count), 64'h0);
        check("rst_pulse", 64'(drop_pulse), 64'h0);
        rst_n = 1'b1;
        tick();

        // Routing, each word visible one cycle after acceptance.
        drive(1'b1, 2'd0, 32'd1);
        check("rt_rdy0", 64'(in_ready), 64'h1);
        tick();
        check("rt_v0", 64'(out_valid), 64'h1);
        check("rt_d1", 64'(out_data_1), 64'd1);
        drive(1'b1, 2'd1, 32'd2);
        tick();
        check("rt_v1", 64'(out_valid), 64'h2);
        check("rt_d2", 64'(out_data_2), 64'd2);
        drive(1'b1, 2'd2, 32'd3);
        tick();
        check("rt_v2", 64'(out_valid), 64'h4);
        check("rt_d3", 64'(out_data_3), 64'd3);
        drive(1'b0, 2'd0, 32'd0);
        tick();
        check("rt_empty", 64'(out_valid), 64'h0);
        check("rt_keep1", 64'(out_data_1), 64'd1);

        // Backpressure on channel 1.
        out_ready = 3'b110;
        drive(1'b1, 2'd0, 32'hA5);
        check("bp_rdy_a", 64'(in_ready), 64'h1);
        tick();
        check("bp_v_a", 64'(out_valid[0]), 64'h1);
        check("bp_d_a", 64'(out_data_1), 64'hA5);
        drive(1'b1, 2'd0, 32'h5A);
        check("bp_rdy_stall", 64'(in_ready), 64'h0);
        tick();
        check("bp_hold_d", 64'(out_data_1), 64'hA5);
        check("bp_hold_v", 64'(out_valid[0]), 64'h1);
        out_ready = 3'b111;
        #1;
        check("bp_rdy_release", 64'(in_ready), 64'h1);
        tick();
        check("bp_d_b", 64'(out_data_1), 64'h5A);
        check("bp_v_b", 64'(out_valid[0]), 64'h1);
        drive(1'b0, 2'd0, 32'd0);
        tick();
        check("bp_drain", 64'(out_valid[0]), 64'h0);

        // Back-to-back throughput on channel 3.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 2'd2, 32'(32'h100 + i));
            check("tp_rdy", 64'(in_ready), 64'h1);
            tick();
            check("tp_v", 64'(out_valid[2]), 64'h1);
            check("tp_d", 64'(out_data_3), 64'(32'h100 + i));
        end
        drive(1'b0, 2'd0, 32'd0);
        tick();
        check("tp_end", 64'(out_valid), 64'h0);

        // Channel 1 stalled full does not block channel 2.
        out_ready = 3'b000;
        drive(1'b1, 2'd0, 32'h11);
        tick();
        drive(1'b1, 2'd1, 32'h77);
        check("ind_rdy", 64'(in_ready), 64'h1);
        tick();
        check("ind_v", 64'(out_valid), 64'h3);
        check("ind_d2", 64'(out_data_2), 64'h77);
        check("ind_d1", 64'(out_data_1), 64'h11);
        drive(1'b0, 2'd0, 32'd0);

        // Asynchronous reset with channels full clears them before any edge.
        rst_n = 1'b0;
        #1;
        check("ar_v", 64'(out_valid), 64'h0);
        check("ar_d1", 64'(out_data_1), 64'h0);
        check("ar_d2", 64'(out_data_2), 64'h0);
        check("ar_d3", 64'(out_data_3), 64'h0);
        check("ar_cnt", 64'(drop_count), 64'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Drops: 300 words to select 3, counter saturates at 255.
        out_ready = 3'b000;
        drive(1'b1, 2'd2, 32'h33);
        tick();
        pulses = 0;
        lows   = 0;
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 2'd3, 32'(i));
            if (!in_ready) lows++;
            tick();
            if (drop_pulse) pulses++;
            if (i == 0) check("dr_cnt1", 64'(drop_count), 64'h1);
        end
        check("dr_lows", 64'(lows), 64'h0);
        check("dr_pulses", 64'(pulses), 64'd300);
        check("dr_sat", 64'(drop_count), 64'd255);
        check("dr_v", 64'(out_valid), 64'h4);
        check("dr_d3", 64'(out_data_3), 64'h33);
        drive(1'b0, 2'd3, 32'd0);
        tick();
        check("dr_pulse_off", 64'(drop_pulse), 64'h0);
        check("dr_sat_hold", 64'(drop_count), 64'd255);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
